// File: rtl/bf_pkg.sv
// bf_pkg: shared definitions for the bfcpu bus interface unit.
//   - bus_ctl phase codes driven on uo_out[2:1]
//   - memory-type codes carried on bus_mtype (reserved codes pass through)
//   - FSM state enumeration used by bf_bus_if
package bf_pkg;

  localparam logic [1:0] CTL_IDLE = 2'b00;
  localparam logic [1:0] CTL_ALO  = 2'b01;
  localparam logic [1:0] CTL_AHI  = 2'b10;
  localparam logic [1:0] CTL_DAT  = 2'b11;

  localparam logic [2:0] MT_PROG  = 3'd0;
  localparam logic [2:0] MT_DATA  = 3'd1;
  localparam logic [2:0] MT_IOIN  = 3'd2;
  localparam logic [2:0] MT_IOOUT = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALO_REQ,
    ST_ALO_REL,
    ST_AHI_REQ,
    ST_AHI_REL,
    ST_DAT_REQ,
    ST_DAT_REL,
    ST_RESP
  } state_t;

endpackage

// File: rtl/bf_bus_if_if.sv
// bf_bus_if_if: core request/response and external byte-bus signals of the
// bfcpu bus interface unit.
//   slave  : view of the bus interface unit (takes core requests, drives pins)
//   master : view of the surroundings (core + external responder)
interface bf_bus_if_if;
  // core request / response
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_mtype;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        resp_valid;
  logic [7:0]  resp_rdata;
  logic        resp_err;
  // external pins
  logic        bus_rdy;
  logic [1:0]  bus_ctl;
  logic [2:0]  bus_mtype;
  logic        bus_ack;
  logic [7:0]  bus_din;
  logic [7:0]  bus_dout;
  logic [7:0]  bus_oe;

  modport slave (
    input  req_valid, req_write, req_mtype, req_addr, req_wdata, bus_ack, bus_din,
    output req_ready, resp_valid, resp_rdata, resp_err,
           bus_rdy, bus_ctl, bus_mtype, bus_dout, bus_oe
  );

  modport master (
    output req_valid, req_write, req_mtype, req_addr, req_wdata, bus_ack, bus_din,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           bus_rdy, bus_ctl, bus_mtype, bus_dout, bus_oe
  );
endinterface

// File: rtl/bf_sync.sv
// bf_sync: STAGES-deep flop chain bringing an asynchronous level into the
// clk domain. STAGES must be at least 2.
//   clk : system clock
//   rst : asynchronous active-high reset, clears every stage
//   d   : asynchronous input
//   q   : synchronized output
module bf_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/bf_bus_if.sv
// bf_bus_if: bfcpu bus interface unit. Turns one accepted core request into
// a 4-phase rdy/ack byte-serial transfer (addr lo, addr hi, data) and
// returns a one-cycle resp_valid with read data.
//   clk : system clock
//   rst : asynchronous active-high reset (releases the bus immediately)
//   bus : bf_bus_if_if.slave -- req_*/resp_* to the core, bus_* to the pins
// Optional feature macro: BUS_TIMEOUT_EN -- aborts a phase whose ack edge
// does not arrive within TIMEOUT_CYCLES and reports resp_err=1.
module bf_bus_if
  import bf_pkg::*;
#(
  parameter int ACK_SYNC_STAGES = 2,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic          clk,
  input  logic          rst,
  bf_bus_if_if.slave    bus
);

  // Reject unusable configurations at elaboration.
  if (ACK_SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("bf_bus_if: ACK_SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  state_t      state_reg, state_next;
  logic        write_reg;
  logic [2:0]  mtype_reg;
  logic [15:0] addr_reg;
  logic [7:0]  wdata_reg;
  logic [7:0]  rdata_reg;
  logic        ack_s;
  logic        in_phase;
  logic        timeout_hit;

  bf_sync #(.STAGES(ACK_SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.bus_ack),
    .q   (ack_s)
  );

  assign in_phase = (state_reg != ST_IDLE) && (state_reg != ST_RESP);

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_reg;
  logic             err_reg;

  assign timeout_hit = in_phase && (cnt_reg == TO_VAL);

  // Counts cycles spent in the current REQ/REL state; any state change restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (state_next != state_reg) begin
      cnt_reg <= '0;
    end else if (in_phase) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Error flag is decided on the way into RESP and held until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (state_next == ST_RESP && state_reg != ST_RESP) begin
      err_reg <= timeout_hit;
    end
  end

  assign bus.resp_err = err_reg;
`else
  assign timeout_hit  = 1'b0;
  assign bus.resp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // One step per observed ack_s level, so a stale high ack still forces a
  // full low/high cycle before the next phase.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (bus.req_valid) state_next = ST_ALO_REQ;
      ST_ALO_REQ: if (ack_s)         state_next = ST_ALO_REL;
      ST_ALO_REL: if (!ack_s)        state_next = ST_AHI_REQ;
      ST_AHI_REQ: if (ack_s)         state_next = ST_AHI_REL;
      ST_AHI_REL: if (!ack_s)        state_next = ST_DAT_REQ;
      ST_DAT_REQ: if (ack_s)         state_next = ST_DAT_REL;
      ST_DAT_REL: if (!ack_s)        state_next = ST_RESP;
      ST_RESP:                       state_next = ST_IDLE;
      default:                       state_next = ST_IDLE;
    endcase
    if (timeout_hit) begin
      state_next = ST_RESP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_reg <= 1'b0;
      mtype_reg <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else begin
      if (state_reg == ST_IDLE && bus.req_valid) begin
        write_reg <= bus.req_write;
        mtype_reg <= bus.req_mtype;
        addr_reg  <= bus.req_addr;
        wdata_reg <= bus.req_wdata;
      end
      // The responder holds din valid while ack is high; capture on the
      // cycle the synchronized ack is first seen in DAT_REQ.
      if (state_reg == ST_DAT_REQ && ack_s && !write_reg && !timeout_hit) begin
        rdata_reg <= bus.bus_din;
      end
    end
  end

  // Moore outputs decoded from the state so reset releases the pins at once.
  always_comb begin
    bus.bus_rdy   = 1'b0;
    bus.bus_ctl   = CTL_IDLE;
    bus.bus_mtype = '0;
    bus.bus_dout  = '0;
    bus.bus_oe    = '0;
    case (state_reg)
      ST_ALO_REQ, ST_ALO_REL: begin
        bus.bus_rdy   = (state_reg == ST_ALO_REQ);
        bus.bus_ctl   = CTL_ALO;
        bus.bus_mtype = mtype_reg;
        bus.bus_dout  = addr_reg[7:0];
        bus.bus_oe    = 8'hFF;
      end
      ST_AHI_REQ, ST_AHI_REL: begin
        bus.bus_rdy   = (state_reg == ST_AHI_REQ);
        bus.bus_ctl   = CTL_AHI;
        bus.bus_mtype = mtype_reg;
        bus.bus_dout  = addr_reg[15:8];
        bus.bus_oe    = 8'hFF;
      end
      ST_DAT_REQ, ST_DAT_REL: begin
        bus.bus_rdy   = (state_reg == ST_DAT_REQ);
        bus.bus_ctl   = CTL_DAT;
        bus.bus_mtype = mtype_reg;
        bus.bus_dout  = write_reg ? wdata_reg : 8'h00;
        bus.bus_oe    = write_reg ? 8'hFF : 8'h00;
      end
      default: begin
      end
    endcase
  end

  assign bus.req_ready  = (state_reg == ST_IDLE);
  assign bus.resp_valid = (state_reg == ST_RESP);
  assign bus.resp_rdata = rdata_reg;

endmodule
